// File: rtl/aes256_ctr_arbiter.sv
// Packet-granular round-robin arbiter sharing one AES-256 CTR core among NUM_REQ
// AXI-Stream requesters; requests pass with zero latency, results route back to the owner.

module aes256_ctr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_axis_tvalid,
    output logic [NUM_REQ-1:0]        req_axis_tready,
    input  logic [NUM_REQ-1:0]        req_axis_tlast,
    input  logic [NUM_REQ-1:0]        req_axis_tuser,
    input  logic [NUM_REQ-1:0][127:0] req_axis_tdata,
    input  logic [NUM_REQ-1:0][15:0]  req_axis_tkeep,
    output logic                      core_s_axis_tvalid,
    output logic [127:0]              core_s_axis_tdata,
    output logic [15:0]               core_s_axis_tkeep,
    output logic                      core_s_axis_tlast,
    output logic                      core_s_axis_tuser,
    input  logic                      core_s_axis_tready,
    input  logic                      core_m_axis_tvalid,
    input  logic [127:0]              core_m_axis_tdata,
    input  logic [15:0]               core_m_axis_tkeep,
    input  logic                      core_m_axis_tlast,
    output logic                      core_m_axis_tready,
    output logic [NUM_REQ-1:0]        rsp_axis_tvalid,
    input  logic [NUM_REQ-1:0]        rsp_axis_tready,
    output logic [127:0]              rsp_axis_tdata,
    output logic [15:0]               rsp_axis_tkeep,
    output logic                      rsp_axis_tlast,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      protocol_err
);

    typedef enum logic [1:0] {IDLE, FWD, DRAIN} state_e;

    localparam logic [1:0]      HDR_DONE  = 2'd3;
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(NUM_REQ - 1);

    state_e          state_q, state_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;
    logic [1:0]      hdr_q, hdr_d;
    logic            perr_q, perr_d;

    logic            in_fire, out_fire;
    logic [ID_W-1:0] rr_idx, rr_cand;
    logic            rr_found;

    assign in_fire  = (state_q == FWD) && req_axis_tvalid[grant_q] && core_s_axis_tready;
    assign out_fire = (state_q != IDLE) && core_m_axis_tvalid && rsp_axis_tready[grant_q];

    // Round robin: first valid requester strictly after the last one served, with wrap.
    always_comb begin
        rr_idx   = '0;
        rr_cand  = '0;
        rr_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            rr_cand = ID_W'((int'(last_grant_q) + i) % NUM_REQ);
            if (!rr_found && req_axis_tvalid[rr_cand]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= LAST_INIT;
            hdr_q        <= '0;
            perr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            hdr_q        <= hdr_d;
            perr_q       <= perr_d;
        end
    end

    // NOTE: every signal gets a hold/default value first so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        hdr_d        = hdr_q;
        perr_d       = perr_q;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    grant_d = rr_idx;
                    hdr_d   = '0;
                    state_d = FWD;
                end
            end
            FWD: begin
                if (in_fire) begin
                    if (hdr_q != HDR_DONE) begin
                        hdr_d = hdr_q + 2'd1;
                        if (req_axis_tlast[grant_q]) perr_d = 1'b1;
                    end else if (req_axis_tlast[grant_q]) begin
                        state_d = DRAIN;
                    end
                end
                // The core closing a result stream before the request ended is a violation.
                if (out_fire && core_m_axis_tlast) begin
                    perr_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (out_fire && core_m_axis_tlast) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_axis_tready    = '0;
        core_s_axis_tvalid = 1'b0;
        core_s_axis_tdata  = '0;
        core_s_axis_tkeep  = '0;
        core_s_axis_tlast  = 1'b0;
        core_s_axis_tuser  = 1'b0;
        core_m_axis_tready = 1'b0;
        rsp_axis_tvalid    = '0;
        rsp_axis_tdata     = '0;
        rsp_axis_tkeep     = '0;
        rsp_axis_tlast     = 1'b0;
        if (state_q == FWD) begin
            core_s_axis_tvalid       = req_axis_tvalid[grant_q];
            core_s_axis_tdata        = req_axis_tdata[grant_q];
            core_s_axis_tkeep        = req_axis_tkeep[grant_q];
            core_s_axis_tuser        = req_axis_tuser[grant_q];
            core_s_axis_tlast        = req_axis_tlast[grant_q] && (hdr_q == HDR_DONE);
            req_axis_tready[grant_q] = core_s_axis_tready;
        end
        if (state_q != IDLE) begin
            rsp_axis_tvalid[grant_q] = core_m_axis_tvalid;
            core_m_axis_tready       = rsp_axis_tready[grant_q];
            rsp_axis_tdata           = core_m_axis_tdata;
            rsp_axis_tkeep           = core_m_axis_tkeep;
            rsp_axis_tlast           = core_m_axis_tlast;
        end
    end

    assign busy         = (state_q != IDLE);
    assign grant_id     = grant_q;
    assign protocol_err = perr_q;

endmodule

// File: tb/tb_aes256_ctr_arbiter.sv
// Scoreboard bench for aes256_ctr_arbiter: a toy CTR core model, per-requester expected
// result queues and a packet-level round-robin model checked by an independent monitor.

module tb_aes256_ctr_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic                clk, rst_n;
    logic [N-1:0]        req_axis_tvalid, req_axis_tready, req_axis_tlast, req_axis_tuser;
    logic [N-1:0][127:0] req_axis_tdata;
    logic [N-1:0][15:0]  req_axis_tkeep;
    logic                core_s_axis_tvalid, core_s_axis_tlast, core_s_axis_tuser, core_s_axis_tready;
    logic [127:0]        core_s_axis_tdata;
    logic [15:0]         core_s_axis_tkeep;
    logic                core_m_axis_tvalid, core_m_axis_tlast, core_m_axis_tready;
    logic [127:0]        core_m_axis_tdata;
    logic [15:0]         core_m_axis_tkeep;
    logic [N-1:0]        rsp_axis_tvalid, rsp_axis_tready;
    logic [127:0]        rsp_axis_tdata;
    logic [15:0]         rsp_axis_tkeep;
    logic                rsp_axis_tlast;
    logic                busy, protocol_err;
    logic [IW-1:0]       grant_id;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] data;
        logic [15:0]  keep;
        logic         last;
        logic         user;
    } beat_t;

    beat_t        req_q[N][$];
    beat_t        exp_q[N][$];
    beat_t        core_fifo[$];
    int           cidx;
    logic [127:0] c_klo, c_khi, c_ctr;
    bit           rand_en, hold_rsp, perr_exp;
    int           model_last, model_grant;
    int           grant_log[$];
    bit           busy_prev;
    logic [N-1:0] tv_prev;

    aes256_ctr_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_axis_tvalid(req_axis_tvalid), .req_axis_tready(req_axis_tready),
        .req_axis_tlast(req_axis_tlast), .req_axis_tuser(req_axis_tuser),
        .req_axis_tdata(req_axis_tdata), .req_axis_tkeep(req_axis_tkeep),
        .core_s_axis_tvalid(core_s_axis_tvalid), .core_s_axis_tdata(core_s_axis_tdata),
        .core_s_axis_tkeep(core_s_axis_tkeep), .core_s_axis_tlast(core_s_axis_tlast),
        .core_s_axis_tuser(core_s_axis_tuser), .core_s_axis_tready(core_s_axis_tready),
        .core_m_axis_tvalid(core_m_axis_tvalid), .core_m_axis_tdata(core_m_axis_tdata),
        .core_m_axis_tkeep(core_m_axis_tkeep), .core_m_axis_tlast(core_m_axis_tlast),
        .core_m_axis_tready(core_m_axis_tready),
        .rsp_axis_tvalid(rsp_axis_tvalid), .rsp_axis_tready(rsp_axis_tready),
        .rsp_axis_tdata(rsp_axis_tdata), .rsp_axis_tkeep(rsp_axis_tkeep),
        .rsp_axis_tlast(rsp_axis_tlast),
        .busy(busy), .grant_id(grant_id), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Toy keystream standing in for AES: only routing and framing matter here.
    function automatic logic [127:0] ks(input logic [127:0] klo, input logic [127:0] khi,
                                        input logic [127:0] ctr, input int j);
        return klo ^ {khi[63:0], khi[127:64]} ^ (ctr + 128'(j));
    endfunction

    function automatic bit all_empty();
        bit e;
        e = (core_fifo.size() == 0);
        for (int r = 0; r < N; r++) e = e && (req_q[r].size() == 0) && (exp_q[r].size() == 0);
        return e;
    endfunction

    task automatic issue(input int r, input int ntext, input bit hdr_err);
        beat_t        b, e;
        logic [127:0] klo, khi, ctr;
        klo = rand128(); khi = rand128(); ctr = rand128();
        b.keep = '1; b.user = 1'b0;
        b.data = klo; b.last = 1'b0;    req_q[r].push_back(b);
        b.data = khi; b.last = hdr_err; req_q[r].push_back(b);
        b.data = ctr; b.last = 1'b0;    req_q[r].push_back(b);
        for (int j = 0; j < ntext; j++) begin
            b.data = rand128();
            b.keep = 16'($urandom) | 16'h0001;
            b.last = (j == ntext - 1);
            b.user = 1'($urandom_range(1));
            req_q[r].push_back(b);
            e      = b;
            e.data = b.data ^ ks(klo, khi, ctr, j);
            e.user = 1'b0;
            exp_q[r].push_back(e);
        end
        if (hdr_err) perr_exp = 1'b1;
    endtask

    task automatic core_accept();
        beat_t o;
        if (cidx < 3) check("core_hdr_tlast", core_s_axis_tlast, 1'b0);
        case (cidx)
            0: c_klo = core_s_axis_tdata;
            1: c_khi = core_s_axis_tdata;
            2: c_ctr = core_s_axis_tdata;
            default: begin
                o.data = core_s_axis_tdata ^ ks(c_klo, c_khi, c_ctr, cidx - 3);
                o.keep = core_s_axis_tkeep;
                o.last = core_s_axis_tlast;
                o.user = 1'b0;
                core_fifo.push_back(o);
            end
        endcase
        cidx = core_s_axis_tlast ? 0 : cidx + 1;
    endtask

    task automatic drive();
        for (int r = 0; r < N; r++) begin
            if (req_q[r].size() > 0 && (!rand_en || $urandom_range(3) != 0)) begin
                req_axis_tvalid[r] = 1'b1;
                req_axis_tdata[r]  = req_q[r][0].data;
                req_axis_tkeep[r]  = req_q[r][0].keep;
                req_axis_tlast[r]  = req_q[r][0].last;
                req_axis_tuser[r]  = req_q[r][0].user;
            end else begin
                req_axis_tvalid[r] = 1'b0;
                req_axis_tlast[r]  = 1'b0;
            end
            rsp_axis_tready[r] = !hold_rsp && (!rand_en || $urandom_range(3) != 0);
        end
        core_s_axis_tready = !rand_en || $urandom_range(3) != 0;
        if (core_fifo.size() > 0 && (!rand_en || $urandom_range(3) != 0)) begin
            core_m_axis_tvalid = 1'b1;
            core_m_axis_tdata  = core_fifo[0].data;
            core_m_axis_tkeep  = core_fifo[0].keep;
            core_m_axis_tlast  = core_fifo[0].last;
        end else begin
            core_m_axis_tvalid = 1'b0;
        end
    endtask

    // Requesters, rsp sinks and the toy core: sample at negedge, update just after posedge.
    initial begin
        logic [N-1:0] rf;
        logic         cm_f;
        req_axis_tvalid = '0; req_axis_tlast = '0; req_axis_tuser = '0;
        req_axis_tdata  = '0; req_axis_tkeep = '0; rsp_axis_tready = '0;
        core_s_axis_tready = 1'b0; core_m_axis_tvalid = 1'b0;
        core_m_axis_tdata  = '0; core_m_axis_tkeep = '0; core_m_axis_tlast = 1'b0;
        forever begin
            @(negedge clk);
            rf   = req_axis_tvalid & req_axis_tready;
            cm_f = core_m_axis_tvalid & core_m_axis_tready;
            if (rst_n && core_s_axis_tvalid && core_s_axis_tready) core_accept();
            @(posedge clk);
            #1;
            if (rst_n) begin
                for (int r = 0; r < N; r++)
                    if (rf[r] && req_q[r].size() > 0) void'(req_q[r].pop_front());
                if (cm_f && core_fifo.size() > 0) void'(core_fifo.pop_front());
            end
            drive();
        end
    end

    // Monitor: round-robin grant model plus per-requester result scoreboard.
    initial begin
        logic [N-1:0] fire, oh;
        int           e, idx;
        beat_t        x;
        busy_prev = 1'b0; tv_prev = '0; model_last = N - 1; model_grant = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_last = N - 1; busy_prev = 1'b0; tv_prev = '0;
            end else begin
                if (busy && !busy_prev) begin
                    e = -1;
                    for (int i = 1; i <= N; i++) begin
                        idx = (model_last + i) % N;
                        if (e < 0 && tv_prev[idx]) e = idx;
                    end
                    check("grant_rr", grant_id, e);
                    grant_log.push_back(int'(grant_id));
                    model_grant = e;
                end
                if (!busy && busy_prev) model_last = model_grant;
                oh = '0;
                if (model_grant >= 0) oh[model_grant] = 1'b1;
                fire = req_axis_tvalid & req_axis_tready;
                if (fire != '0) check("req_owner", fire, oh);
                fire = rsp_axis_tvalid & rsp_axis_tready;
                if (fire != '0) begin
                    check("rsp_owner", rsp_axis_tvalid, oh);
                    if (exp_q[model_grant].size() == 0) begin
                        checks++; failures++;
                        $display("FAIL rsp_extra: requester %0d got beat %0h expected none",
                                 model_grant, rsp_axis_tdata);
                    end else begin
                        x = exp_q[model_grant].pop_front();
                        check("rsp_data", rsp_axis_tdata, x.data);
                        check("rsp_keep", rsp_axis_tkeep, x.keep);
                        check("rsp_last", rsp_axis_tlast, x.last);
                    end
                end
                busy_prev = busy;
                tv_prev   = busy ? '0 : req_axis_tvalid;
            end
        end
    end

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            @(negedge clk);
            #1;
            done = all_empty() && !busy;
        end
        check(tag, done, 1'b1);
    endtask

    task automatic check_order(input string tag, input int e[$]);
        check({tag, "_len"}, grant_log.size(), e.size());
        if (grant_log.size() == e.size())
            for (int i = 0; i < e.size(); i++) check(tag, grant_log[i], e[i]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_grant"}, grant_id, '0);
        check({tag, "_perr"}, protocol_err, 1'b0);
        check({tag, "_req_tready"}, req_axis_tready, '0);
        check({tag, "_core_s_tvalid"}, core_s_axis_tvalid, 1'b0);
        check({tag, "_core_s_tdata"}, core_s_axis_tdata, '0);
        check({tag, "_core_m_tready"}, core_m_axis_tready, 1'b0);
        check({tag, "_rsp_tvalid"}, rsp_axis_tvalid, '0);
        check({tag, "_rsp_tdata"}, rsp_axis_tdata, '0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t expected finish", $time);
        $fatal(1);
    end

    initial begin
        bit ok;
        cidx = 0; rand_en = 1'b0; hold_rsp = 1'b0; perr_exp = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        #1 rst_n = 1'b1;

        // Contention: every requester valid, requester 0 holding two packets.
        grant_log.delete();
        issue(0, 1, 0); issue(1, 1, 0); issue(2, 1, 0); issue(3, 1, 0); issue(0, 1, 0);
        wait_idle("idle_contention", 2000);
        check_order("order_contention", '{0, 1, 2, 3, 0});

        // Single requester: busy rises the cycle after tvalid is first seen.
        issue(1, 2, 0);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = req_axis_tvalid[1];
        end
        check("single_tvalid_seen", ok, 1'b1);
        check("single_busy_idle_cycle", busy, 1'b0);
        @(negedge clk);
        #1;
        check("single_busy_rise", busy, 1'b1);
        check("single_grant", grant_id, 2'd1);
        wait_idle("idle_single", 2000);
        check("single_busy_after", busy, 1'b0);

        // Fairness across the wrap: after 3 is served, 0 beats 2.
        grant_log.delete();
        issue(3, 1, 0);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = busy && grant_id == 2'd3;
        end
        check("wrap_grant3_seen", ok, 1'b1);
        issue(0, 1, 0); issue(2, 1, 0);
        wait_idle("idle_wrap", 2000);
        check_order("order_wrap", '{3, 0, 2});

        // Result backpressure held for five cycles in DRAIN.
        hold_rsp = 1'b1;
        issue(2, 3, 0);
        ok = 1'b0;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = busy && req_q[2].size() == 0;
        end
        check("bp_reach_drain", ok, 1'b1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            #1;
            check("bp_core_m_tready", core_m_axis_tready, 1'b0);
            check("bp_rsp_tvalid", rsp_axis_tvalid, 4'b0100);
            check("bp_req_tready", req_axis_tready, '0);
            check("bp_busy", busy, 1'b1);
            check("bp_pending", exp_q[2].size(), 3);
            if (exp_q[2].size() > 0) check("bp_rsp_tdata", rsp_axis_tdata, exp_q[2][0].data);
        end
        hold_rsp = 1'b0;
        wait_idle("idle_bp", 2000);

        // tlast on a header beat: flagged, filtered, packet still completes.
        check("perr_before", protocol_err, 1'b0);
        issue(1, 2, 1);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = protocol_err;
        end
        check("perr_set", ok, 1'b1);
        check("perr_still_fwd", busy, 1'b1);
        wait_idle("idle_perr", 2000);
        issue(3, 1, 0);
        wait_idle("idle_perr2", 2000);
        check("perr_sticky", protocol_err, perr_exp);

        // Randomized traffic with gaps and backpressure on every interface.
        rand_en = 1'b1;
        for (int k = 0; k < 24; k++) begin
            issue($urandom_range(N - 1), $urandom_range(1, 4), 0);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        wait_idle("idle_random", 8000);
        rand_en = 1'b0;

        // Reset during the second text beat abandons the packet; requester 0 wins next.
        issue(2, 2, 0);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            #1;
            ok = busy && req_q[2].size() == 1 && req_axis_tvalid[2];
        end
        check("rst_reach_text2", ok, 1'b1);
        #1 rst_n = 1'b0;
        for (int r = 0; r < N; r++) begin
            req_q[r].delete();
            exp_q[r].delete();
        end
        core_fifo.delete();
        cidx = 0; perr_exp = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        #2 rst_n = 1'b1;
        grant_log.delete();
        issue(2, 1, 0); issue(0, 1, 0);
        wait_idle("idle_after_rst", 2000);
        check_order("order_after_rst", '{0, 2});
        check("perr_after_rst", protocol_err, perr_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes256_ctr_arbiter.md
AES256_CTR_ARBITER -- requirements
Module: aes256_ctr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8); SHALL set all per-requester vector widths.
REQ-002 Parameter ID_W, default 2, width of Grant_id = clog2(NUM_REQ); SHALL be at least 1.
REQ-003 Clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-004 Rst_n  in  1  asynchronous active-low reset.
REQ-005 Req_axis_tvalid/tready/tlast/tuser  in/out/in/in  NUM_REQ each  per-requester AXI-S slave; bit i belongs to requester i.
REQ-006 Req_axis_tdata  in  NUM_REQ x 128  per-requester data.
REQ-007 Req_axis_tkeep  in  NUM_REQ x 16  per-requester byte keep.
REQ-008 Core_s_axis_tvalid/tdata/tkeep/tlast/tuser  out  1/128/16/1/1  master toward the shared CTR core.
REQ-009 Core_s_axis_tready  in  1  core accepts input beat.
REQ-010 Core_m_axis_tvalid/tdata/tkeep/tlast  in  1/128/16/1  result stream from the core.
REQ-011 Core_m_axis_tready  out  1  result accepted.
REQ-012 Rsp_axis_tvalid  out  NUM_REQ  per-requester result valid.
REQ-013 Rsp_axis_tready  in  NUM_REQ  per-requester result ready.
REQ-014 Rsp_axis_tdata/tkeep/tlast  out  128/16/1  shared result bus, meaningful only with the matching Rsp_axis_tvalid bit.
REQ-015 Busy  out  1  high when state is not IDLE.
REQ-016 Grant_id  out  ID_W  index of the current or last granted requester.
REQ-017 Protocol_err  out  1  sticky protocol-violation flag.

Function
REQ-018 Packet format: beat0 key[127:0], beat1 key[255:128], beat2 counter, beats 3..n text; tlast SHALL be legal only on a text beat.
REQ-019 States SHALL be IDLE, FWD, DRAIN; arbitration granularity SHALL be one whole packet.
REQ-020 IDLE: if any Req_axis_tvalid bit is set, grant SHALL register the first set bit searching from last_grant+1 upward with wrap (round robin); transition to FWD; no beat is passed in the IDLE cycle.
REQ-021 FWD: Core_s_axis_* SHALL combinationally mirror requester Grant_id (zero latency, no buffering); Req_axis_tready[g] = Core_s_axis_tready; all other tready bits 0.
REQ-022 A 2-bit saturating header counter SHALL count accepted beats 0..3; tlast on beats 0..2 SHALL be forced to 0 toward the core and SHALL set Protocol_err.
REQ-023 FWD -> DRAIN on an accepted beat with tlast=1 and header count = 3; the input side SHALL then drive tready 0 to all requesters.
REQ-024 FWD and DRAIN: Rsp_axis_tvalid[g] = Core_m_axis_tvalid; other bits 0; Core_m_axis_tready = Rsp_axis_tready[g]; Rsp data/keep/tlast SHALL mirror the core.
REQ-025 DRAIN -> IDLE on an accepted core beat with tlast=1; last_grant SHALL update to g on that transition.
REQ-026 An accepted core beat with tlast=1 while in FWD SHALL set Protocol_err and force IDLE.
REQ-027 In IDLE, Core_s_axis_tvalid and Core_m_axis_tready SHALL be 0, and all Rsp_axis_tvalid bits SHALL be 0; core output beats in IDLE SHALL be stalled, not dropped.
REQ-028 Requesters dropping tvalid mid-packet SHALL keep the grant; there is no timeout.
REQ-029 Protocol_err SHALL clear only on reset.

Reset
REQ-030 Rst_n low SHALL immediately force IDLE, Busy=0, Grant_id=0, header count 0, Protocol_err=0, and last_grant=NUM_REQ-1, so requester 0 wins first; all outputs SHALL be 0 combinationally.
REQ-031 Reset mid-packet SHALL abandon the packet; the shared core SHALL be reset in the same domain by the integrator.

Verification
REQ-032 Single requester: req1 sends key K, counter C, 2 text beats with tlast on beat 4 -> Grant_id=1, Busy rises one cycle after tvalid, 2 Rsp beats on bit 1 only, last Rsp tlast=1, IDLE afterwards.
REQ-033 Contention: req0..3 all valid continuously, 1-text-beat packets -> grants in order 0,1,2,3,0 with no interleaving of beats between packets.
REQ-034 Fairness with wrap: last_grant=3 and req0 and req2 valid -> req0 granted; next packet -> req2.
REQ-035 Backpressure: Rsp_axis_tready[g]=0 for 5 cycles during DRAIN -> Core_m_axis_tready=0, state held, data bus stable, no beat lost or duplicated.
REQ-036 Header tlast: tlast=1 on beat1 -> core sees tlast=0, Protocol_err=1 and stays 1, packet continues in FWD.
REQ-037 Mid-packet reset: Rst_n low during text beat 2 -> same cycle Busy=0, all tready/tvalid outputs 0; after release req0 is granted first.
